// File: rtl/d_sraml2axi.sv
// d_sraml2axi: SRAM-like data port to single-beat AXI3 master bridge.
// Handles one outstanding request at a time. Ports:
//   clk, resetn (async, active-low)
//   data_req/wr/size/addr/wdata in; data_rdata, data_addr_ok, data_data_ok out
//   AXI AR/R/AW/W/B channels (single-beat, INCR, fixed IDs RD_ID / WR_ID)
// Build option: define D_SRAML2AXI_BRESP_WAIT_EN to complete writes on the B
// response instead of on the last of the AW/W handshakes.
module d_sraml2axi #(
    parameter logic [3:0] RD_ID = 4'd1,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_fin, w_fin;

    // Response ID/status and the latched direction are not needed by the
    // datapath; the direction is taken straight from data_wr at acceptance.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, rid, rresp, rlast, bid, bresp, wr_q};

    assign arid    = RD_ID;
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = WR_ID;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = WR_ID;
    assign wlast   = 1'b1;

    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign awsize     = {1'b0, size_q};
    assign wdata      = wdata_q;
    assign data_rdata = rdata;

    always_comb begin
        wstrb = 4'b1111;
        unique case (size_q)
            2'b00:   wstrb = 4'b0001 << addr_q[1:0];
            2'b01:   wstrb = 4'b0011 << {addr_q[1], 1'b0};
            default: wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            size_q    <= 2'd0;
            wr_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            wr_q      <= wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wr_d         = wr_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        aw_fin       = 1'b0;
        w_fin        = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_addr_ok = 1'b1;
                if (data_req) begin
                    addr_d    = data_addr;
                    wdata_d   = data_wdata;
                    size_d    = data_size;
                    wr_d      = data_wr;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_wr ? WR_AW_W : RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_data_ok = 1'b1;
                    state_d      = IDLE;
                end
            end
            WR_AW_W: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                // A channel counts as finished if it completed earlier or
                // completes now; both may complete in the same cycle.
                aw_fin  = aw_done_q | (awvalid & awready);
                w_fin   = w_done_q | (wvalid & wready);
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_B;
`ifndef D_SRAML2AXI_BRESP_WAIT_EN
                    data_data_ok = 1'b1;
`endif
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = IDLE;
`ifdef D_SRAML2AXI_BRESP_WAIT_EN
                    data_data_ok = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_d_sraml2axi.sv
// tb_d_sraml2axi: randomized self-checking bench for d_sraml2axi.
// Expected per-cycle behaviour is derived from handshake timing arithmetic.
module tb_d_sraml2axi;

    logic        clk;
    logic        resetn;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    d_sraml2axi dut (
        .clk(clk), .resetn(resetn),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read: arready offered ard cycles after AR starts, rvalid rd cycles
    // after entering the R phase. Cycle 0 is the acceptance cycle.
    task automatic do_read(input logic [31:0] addr, input logic [1:0] size,
                           input int ard, input int rd,
                           input logic [31:0] rdat);
        int a_cyc;
        int r_cyc;
        a_cyc = 1 + ard;
        r_cyc = a_cyc + 1 + rd;
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b0; data_size = size;
        data_addr = addr; data_wdata = $urandom;
        arready = 1'b0; rvalid = 1'b0; rdata = $urandom;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++; $display("FAIL rd_accept_addr_ok got=%b exp=1", data_addr_ok);
        end
        checks++;
        if (arvalid !== 1'b0) begin
            errors++; $display("FAIL rd_accept_arvalid got=%b exp=0", arvalid);
        end
        for (int c = 1; c <= r_cyc + 1; c++) begin
            @(posedge clk); #1;
            data_req = (c <= r_cyc) ? 1'($urandom) : 1'b0;
            data_wr = 1'($urandom); data_size = 2'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
            arready = (c == a_cyc);
            rvalid = (c == r_cyc);
            rdata = (c == r_cyc) ? rdat : $urandom;
            @(negedge clk);
            checks++;
            if (arvalid !== (c <= a_cyc)) begin
                errors++; $display("FAIL rd_arvalid c=%0d got=%b exp=%b", c, arvalid, (c <= a_cyc));
            end
            if (c <= a_cyc) begin
                checks++;
                if (araddr !== addr || arsize !== {1'b0, size}) begin
                    errors++; $display("FAIL rd_ar_payload c=%0d got=%h/%0d exp=%h/%0d", c, araddr, arsize, addr, size);
                end
            end
            checks++;
            if (rready !== (c > a_cyc && c <= r_cyc)) begin
                errors++; $display("FAIL rd_rready c=%0d got=%b", c, rready);
            end
            checks++;
            if (data_data_ok !== (c == r_cyc)) begin
                errors++; $display("FAIL rd_data_ok c=%0d got=%b exp=%b", c, data_data_ok, (c == r_cyc));
            end
            if (c == r_cyc) begin
                checks++;
                if (data_rdata !== rdat) begin
                    errors++; $display("FAIL rd_rdata got=%h exp=%h", data_rdata, rdat);
                end
            end
            checks++;
            if (data_addr_ok !== (c > r_cyc)) begin
                errors++; $display("FAIL rd_addr_ok c=%0d got=%b exp=%b", c, data_addr_ok, (c > r_cyc));
            end
            checks++;
            if ({awvalid, wvalid, bready} !== 3'b000) begin
                errors++; $display("FAIL rd_write_chan_idle c=%0d got=%b exp=000", c, {awvalid, wvalid, bready});
            end
        end
        rvalid = 1'b0; arready = 1'b0;
    endtask

    // Write: awready/wready offered awd/wd cycles after the channels open,
    // bvalid bd cycles after entering the B phase.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdat, input int awd,
                            input int wd, input int bd);
        int aw_cyc;
        int w_cyc;
        int l_cyc;
        int b_cyc;
        int ok_cyc;
        int nb;
        int off;
        int aw_hs;
        int w_hs;
        logic [3:0] strb_exp;
        aw_cyc = 1 + awd;
        w_cyc = 1 + wd;
        l_cyc = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        b_cyc = l_cyc + 1 + bd;
`ifdef D_SRAML2AXI_BRESP_WAIT_EN
        ok_cyc = b_cyc;
`else
        ok_cyc = l_cyc;
`endif
        nb = (size >= 2'd2) ? 4 : (1 << size);
        off = int'(addr[1:0]) & (4 - nb);
        strb_exp = 4'(((1 << nb) - 1) << off);
        aw_hs = 0;
        w_hs = 0;
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b1; data_size = size;
        data_addr = addr; data_wdata = wdat;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            errors++; $display("FAIL wr_accept got ok=%b aw=%b w=%b exp=1,0,0", data_addr_ok, awvalid, wvalid);
        end
        for (int c = 1; c <= b_cyc + 1; c++) begin
            @(posedge clk); #1;
            data_req = (c <= b_cyc) ? 1'($urandom) : 1'b0;
            data_wr = 1'($urandom); data_size = 2'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
            awready = (c == aw_cyc) || (c > aw_cyc && 1'($urandom));
            wready = (c == w_cyc) || (c > w_cyc && 1'($urandom));
            bvalid = (c == b_cyc);
            @(negedge clk);
            if (awvalid && awready) aw_hs++;
            if (wvalid && wready) w_hs++;
            checks++;
            if (awvalid !== (c <= aw_cyc)) begin
                errors++; $display("FAIL wr_awvalid c=%0d got=%b exp=%b", c, awvalid, (c <= aw_cyc));
            end
            checks++;
            if (wvalid !== (c <= w_cyc)) begin
                errors++; $display("FAIL wr_wvalid c=%0d got=%b exp=%b", c, wvalid, (c <= w_cyc));
            end
            if (c <= aw_cyc) begin
                checks++;
                if (awaddr !== addr || awsize !== {1'b0, size}) begin
                    errors++; $display("FAIL wr_aw_payload c=%0d got=%h/%0d exp=%h/%0d", c, awaddr, awsize, addr, size);
                end
            end
            if (c <= w_cyc) begin
                checks++;
                if (wdata !== wdat || wstrb !== strb_exp || wlast !== 1'b1) begin
                    errors++; $display("FAIL wr_w_payload c=%0d got=%h/%b exp=%h/%b", c, wdata, wstrb, wdat, strb_exp);
                end
            end
            checks++;
            if (bready !== (c > l_cyc && c <= b_cyc)) begin
                errors++; $display("FAIL wr_bready c=%0d got=%b", c, bready);
            end
            checks++;
            if (data_data_ok !== (c == ok_cyc)) begin
                errors++; $display("FAIL wr_data_ok c=%0d got=%b exp=%b", c, data_data_ok, (c == ok_cyc));
            end
            checks++;
            if (data_addr_ok !== (c > b_cyc)) begin
                errors++; $display("FAIL wr_addr_ok c=%0d got=%b exp=%b", c, data_addr_ok, (c > b_cyc));
            end
            checks++;
            if ({arvalid, rready} !== 2'b00) begin
                errors++; $display("FAIL wr_read_chan_idle c=%0d got=%b exp=00", c, {arvalid, rready});
            end
        end
        checks++;
        if (aw_hs !== 1 || w_hs !== 1) begin
            errors++; $display("FAIL wr_hs_count got aw=%0d w=%0d exp=1,1", aw_hs, w_hs);
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0;
        rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0;
        bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, data_data_ok} !== 6'd0) begin
            errors++; $display("FAIL reset_valids got=%b exp=000000", {arvalid, rready, awvalid, wvalid, bready, data_data_ok});
        end
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++; $display("FAIL reset_addr_ok got=%b exp=1", data_addr_ok);
        end
        checks++;
        if (araddr !== 32'd0 || awaddr !== 32'd0 || wdata !== 32'd0) begin
            errors++; $display("FAIL reset_latched got=%h/%h/%h exp=0", araddr, awaddr, wdata);
        end
        checks++;
        if ({arlen, awlen, arlock, awlock, arcache, awcache, arprot, awprot} !== 26'd0) begin
            errors++; $display("FAIL const_zero got=%h exp=0", {arlen, awlen, arlock, awlock, arcache, awcache, arprot, awprot});
        end
        checks++;
        if (arburst !== 2'b01 || awburst !== 2'b01 || wlast !== 1'b1) begin
            errors++; $display("FAIL const_burst got=%b/%b/%b exp=01/01/1", arburst, awburst, wlast);
        end
        checks++;
        if (arid !== 4'd1 || awid !== 4'd1 || wid !== 4'd1) begin
            errors++; $display("FAIL const_ids got=%0d/%0d/%0d exp=1", arid, awid, wid);
        end
        resetn = 1'b1;
    endtask

    task automatic test_read_word();
        do_read(32'h1FC0_0004, 2'b10, 0, 1, 32'hDEADBEEF);
    endtask

    task automatic test_byte_write();
        do_write(32'h0000_0003, 2'b00, 32'h1122_3344, 0, 0, 0);
    endtask

    task automatic test_half_write_w_first();
        do_write(32'h0000_0002, 2'b01, $urandom, 3, 0, 0);
    endtask

    task automatic test_bresp_delay();
        do_write(32'h0000_1000, 2'b10, $urandom, 1, 2, 5);
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] a;
        a = $urandom;
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = a;
        @(posedge clk); #1;
        data_req = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        @(negedge clk);
        checks++;
        if (rready !== 1'b1) begin
            errors++; $display("FAIL mid_rready_before got=%b exp=1", rready);
        end
        #1 rvalid = 1'b1; rdata = $urandom;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, data_data_ok} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_outputs got=%b exp=000", {arvalid, rready, data_data_ok});
        end
        checks++;
        if (araddr !== 32'd0 || data_addr_ok !== 1'b1) begin
            errors++; $display("FAIL mid_reset_state got=%h/%b exp=0/1", araddr, data_addr_ok);
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (data_data_ok !== 1'b0 || rready !== 1'b0) begin
                errors++; $display("FAIL mid_reset_stale got=%b/%b exp=0/0", data_data_ok, rready);
            end
        end
        do_read($urandom, 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if (1'($urandom)) begin
                do_write($urandom, 2'($urandom), $urandom, $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 4));
            end else begin
                do_read($urandom, 2'($urandom), $urandom_range(0, 4),
                        $urandom_range(0, 4), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_word();
        test_byte_write();
        test_half_write_w_first();
        test_bresp_delay();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
